fifo_rd_ctrl: RTL

Read-side controller for the `TOP_FIFO` read port. It turns the FIFO's `OE_N`/`EMPTY`/`DOUT` interface into a valid/ready stream for downstream logic. It sits between the FIFO read port and any consumer, such as a UART TX, a checker, or a DMA sink. A 3-entry skid buffer absorbs the FIFO's one-cycle read latency, so the stream sustains one word per clock under backpressure.

---
 rtl/fifo_rd_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: turns the FIFO OE_N/EMPTY/DOUT port into a valid/ready stream.
// A 3-entry skid buffer covers the one-cycle read latency so one word per clock is sustained.
module fifo_rd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  input  logic               FIFO_EMPTY,
  input  logic [WIDTH-1:0]   FIFO_DOUT,
  output logic               FIFO_OE_N,
  output logic [WIDTH-1:0]   M_DATA,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic [COUNT_W-1:0] RD_COUNT,
  output logic               DRAINED
);

  logic               pend_q, pend_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]   buf_q [3];
  logic [WIDTH-1:0]   head;
  logic [COUNT_W-1:0] rd_count_q, rd_count_d;
  logic               issue;
  logic               capture;
  logic               pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every word in flight, so the buffer can never overflow.
  assign issue     = RST_N & ENABLE & ~FIFO_EMPTY &
                     (({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd3);
  assign FIFO_OE_N = ~issue;
  assign capture   = pend_q;
  assign pop       = (cnt_q != 2'd0) & M_READY;

  always_comb begin
    pend_d     = issue;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_count_d = rd_count_q;
    if (capture) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      rd_count_d = rd_count_q + COUNT_W'(1);
    end
    case ({capture, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_q     <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_count_q <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_count_q <= rd_count_d;
      for (int i = 0; i < 3; i++) begin
        if (capture && (wr_ptr_q == 2'(i))) begin
          buf_q[i] <= FIFO_DOUT;
        end
      end
    end
  end

  always_comb begin
    case (rd_ptr_q)
      2'd0:    head = buf_q[0];
      2'd1:    head = buf_q[1];
      default: head = buf_q[2];
    endcase
  end

  assign M_DATA   = head;
  assign M_VALID  = (cnt_q != 2'd0);
  assign RD_COUNT = rd_count_q;
  assign DRAINED  = FIFO_EMPTY & ~pend_q & (cnt_q == 2'd0);

endmodule
